// File: rtl/reg_write_back_pkg.sv
// Shared widths and constants for the register write-back path.
// Register 0 is hardwired, so ZERO_REG is never written nor tracked.
package reg_write_back_pkg;

    localparam int REG_ADDR_BUS = 5;
    localparam int DATA_BUS     = 32;
    localparam int SCOREBOARD_W = 2 ** REG_ADDR_BUS;

    localparam logic [REG_ADDR_BUS-1:0] ZERO_REG = '0;

endpackage

// File: rtl/reg_write_back_hold_buffer.sv
// Single-entry valid/ready skid register holding one long-latency result.
// It also holds a stale flag that tells the drain to discard the result.
module wb_hold_buffer
    import reg_write_back_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_BUS,
    parameter int DATA_W = DATA_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_stale,
    input  logic              drain,
    output logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              stale
);

    // A load only happens while the buffer is empty, so load and drain
    // never overlap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
            stale <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
            stale <= load_stale;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    assign ready = !valid;

endmodule

// File: rtl/reg_write_back.sv
// Merges the in-order pipeline write and buffered long-latency results onto
// the regfile write port, and tracks registers with results still in flight.
module reg_write_back
    import reg_write_back_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_BUS,
    parameter int DATA_W   = DATA_BUS,
    parameter int NUM_REGS = SCOREBOARD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_write_en,
    input  logic [ADDR_W-1:0] mem_write_addr,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              ll_valid,
    input  logic [ADDR_W-1:0] ll_addr,
    input  logic [DATA_W-1:0] ll_data,
    output logic              ll_ready,
    input  logic [ADDR_W-1:0] read_addr_1,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic              pending_1,
    output logic              pending_2,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_addr,
    output logic [DATA_W-1:0] reg_write_data
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] stale;
    logic [NUM_REGS-1:0] pending_next;
    logic [NUM_REGS-1:0] stale_next;

    logic              accept;
    logic              mem_win;
    logic              drain;
    logic              write_buf;
    logic              entry_stale;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              buf_stale;

    assign accept    = ll_valid && ll_ready;
    assign mem_win   = mem_write_en && (mem_write_addr != ZERO_REG);
    assign drain     = buf_valid && !mem_win;
    assign write_buf = drain && !buf_stale && (buf_addr != ZERO_REG);

    wb_hold_buffer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_addr (ll_addr),
        .load_data (ll_data),
        .load_stale(entry_stale),
        .drain     (drain),
        .ready     (ll_ready),
        .valid     (buf_valid),
        .addr      (buf_addr),
        .data      (buf_data),
        .stale     (buf_stale)
    );

    // Update order encodes age: pipeline write, then result accept, then the
    // newly issued claim, which overrides both on a shared address.
    always_comb begin
        pending_next = pending;
        stale_next   = stale;
        entry_stale  = 1'b0;
        if (mem_win && pending[mem_write_addr]) begin
            pending_next[mem_write_addr] = 1'b0;
            stale_next[mem_write_addr]   = 1'b1;
        end
        if (accept && (ll_addr != ZERO_REG)) begin
            entry_stale = stale[ll_addr] || (mem_win && (mem_write_addr == ll_addr));
            pending_next[ll_addr] = 1'b0;
            stale_next[ll_addr]   = 1'b0;
        end
        if (claim_en && (claim_addr != ZERO_REG)) begin
            pending_next[claim_addr] = 1'b1;
            stale_next[claim_addr]   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            stale   <= '0;
        end else begin
            pending <= pending_next;
            stale   <= stale_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_en   <= 1'b0;
            reg_write_addr <= '0;
            reg_write_data <= '0;
        end else begin
            reg_write_en <= mem_win || write_buf;
            if (mem_win) begin
                reg_write_addr <= mem_write_addr;
                reg_write_data <= mem_write_data;
            end else if (write_buf) begin
                reg_write_addr <= buf_addr;
                reg_write_data <= buf_data;
            end
        end
    end

    assign pending_1 = (read_addr_1 != ZERO_REG) && pending[read_addr_1];
    assign pending_2 = (read_addr_2 != ZERO_REG) && pending[read_addr_2];

endmodule
